// File: rtl/uart_tx_param.sv
// UART transmitter: one word per valid/ready handshake, start + LSB-first data + optional parity + stop.
// txd/ready are registered and change on the accepting edge; valid is ignored while a frame is in flight.
module uart_tx_param #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 valid,
  output logic                 ready,
  output logic                 txd,
  output logic                 busy
);

  localparam int   DIV     = (BAUD > 0) ? (CLK_HZ + BAUD / 2) / BAUD : 0;
  localparam int   CW      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int   BW      = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam logic PAR_ODD = (PARITY == 1);

  if (BAUD < 1 || DIV < 2) begin : g_err_div
    $error("uart_tx_param: CLK_HZ/BAUD must give at least 2 cycles per bit");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_err_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_baud;
  logic [BW-1:0]        r_bit;
  logic                 r_stop;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_txd;
  logic                 r_ready;

  state_t               w_state_nxt;
  logic [CW-1:0]        w_baud_nxt;
  logic [BW-1:0]        w_bit_nxt;
  logic                 w_stop_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_par_nxt;
  logic                 w_txd_nxt;
  logic                 w_tick;

  assign w_tick = (r_baud == CW'(DIV - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_stop_nxt  = r_stop;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_txd_nxt   = 1'b1;

    if (r_state != S_IDLE) begin
      w_baud_nxt = w_tick ? '0 : r_baud + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        // ready is high whenever we are idle, so valid alone means a transfer
        if (valid) begin
          w_state_nxt = S_START;
          w_shift_nxt = din;
          w_par_nxt   = (^din) ^ PAR_ODD;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_stop_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit == BW'(DATA_BITS - 1)) begin
            w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
            w_stop_nxt  = 1'b0;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (w_tick) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (!r_stop && STOP_BITS == 2) begin
            w_stop_nxt = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Line level is decoded from the next state so txd is a plain flop output.
    case (w_state_nxt)
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = w_shift_nxt[0];
      S_PAR:   w_txd_nxt = w_par_nxt;
      default: w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_stop  <= w_stop_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_txd   <= w_txd_nxt;
      r_ready <= (w_state_nxt == S_IDLE);
    end
  end

  assign txd   = r_txd;
  assign ready = r_ready;
  assign busy  = ~r_ready;

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter that serialises one parallel word per valid/ready handshake onto a single TX line. It has a built-in baud divider, configurable data width (5–9 bits), optional odd/even parity and 1 or 2 stop bits. It replaces the bare 8-bit parallel-to-serial shift register that currently drives `uart_rxd_out`: it generates proper start/stop framing and bit timing, and tells the producer when it may load the next word.

## Interface

Parameters:
- `CLK_HZ`, 100_000_000, input clock frequency in Hz.
- `BAUD`, 115200, line rate. Derived `DIV = round(CLK_HZ/BAUD)` cycles per bit (868 at defaults).
- `DATA_BITS`, 8, payload width, legal 5..9.
- `PARITY`, 0, selects parity: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1, legal 1 or 2.
- Elaboration error if `DIV < 2` or if any parameter is out of range.

Ports:
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `din`  input  DATA_BITS  word to send; sampled only on acceptance.
- `valid`  input  1  producer has a word on `din`.
- `ready`  output  1  block can accept a word this cycle.
- `txd`  output  1  serial line, idle high, registered.
- `busy`  output  1  frame in progress (`= ~ready`).

## Operation

- Reset values (applied immediately, asynchronously):
  - `txd = 1`, `ready = 1`, `busy = 0`.
  - State `IDLE`; all counters 0.
- Handshake:
  - Transfer occurs on a rising edge where `valid && ready`.
  - `din` is latched into the shift register at that edge.
  - `valid` while `ready = 0` is ignored; no queueing.
  - `din` changes after acceptance do not affect the frame.
- States and transitions:
  - `IDLE` → `START` on transfer.
  - `START` → `DATA` after DIV cycles.
  - `DATA` → `PARITY` (if `PARITY != 0`) or `STOP` after DATA_BITS bit periods.
  - `PARITY` → `STOP` after DIV cycles.
  - `STOP` → `IDLE` after STOP_BITS × DIV cycles.
- Line levels per state:
  - `START`: `txd = 0`.
  - `DATA`: bits go out LSB first.
  - `PARITY`: even = XOR of the data bits; odd = its inverse.
  - `STOP`: `txd = 1`.
  - `IDLE`: `txd = 1`.
- Baud counter counts 0..DIV-1. Terminal count advances the bit index or state.
- Bit index counts 0..DATA_BITS-1.
- Frame length `F = (1 + DATA_BITS + (PARITY?1:0) + STOP_BITS) × DIV` cycles.
- Reset mid-frame: frame aborted, word dropped, `txd` high at once. After release, the block is in `IDLE` with `ready = 1`.

## Timing

- Transfer at edge k: `txd` falls and `ready` drops at edge k (registered outputs).
- The start bit occupies the DIV cycles following edge k.
- Data bit i begins at edge k + (1+i)×DIV.
- The last stop cycle ends at edge k+F. At that edge the block enters `IDLE` and `ready = 1`.
- Back-to-back operation: with `valid` held high, the next transfer occurs at edge k+F+1. The line therefore stays idle-high for exactly 1 cycle between frames.
- `txd` is glitch-free and changes only on clock edges, except on asynchronous reset.
- `busy` is the exact complement of `ready` in every cycle.

## Test plan

- **8N1 single word:** `CLK_HZ=1000`, `BAUD=100` (DIV=10), send `0x41`.
  - Required: `txd` = 0,1,0,0,0,0,0,1,0,1, each level held 10 cycles.
  - Required: `ready` low for exactly 100 cycles.
- **Parity:** 8E1 sending `0x41` → parity bit 0. 8O1 sending `0x41` → parity bit 1. 8E1 sending `0x07` → parity bit 1.
  - Required: frame length 110 cycles in every case.
- **Back-to-back with 2 stop bits:** 8N2, `valid` held high, `0xA5` then `0x3C`.
  - Required: stop level held 20 cycles.
  - Required: second start bit begins 1 cycle after `ready` rises.
  - Required: both words decode correctly.
- **Narrow data:** `DATA_BITS=7`, send `0x55`.
  - Required: 1,0,1,0,1,0,1 after start.
  - Required: frame length 90 cycles; bit 7 of the pattern is never emitted.
- **Reset mid-frame:** assert `rst` during data bit 3 of `0x41`.
  - Required: `txd = 1` and `ready = 1` before the next edge.
  - Required: after release, `0x42` is sent with a correct, clean frame.
- **Ignored input:** pulse `valid` and change `din` repeatedly while `busy = 1`.
  - Required: the frame in flight is unchanged.
  - Required: no extra frame is transmitted.
